control_seq: RTL and testbench
==============================

Name: control_seq

Overview:
Parametrised microcoded control sequencer for the 8-bit bus CPU, successor to the fixed 11-instruction controller. It decodes the opcode from the instruction register and emits one-hot-per-step control strobes and a bus-source select. Over its predecessor it adds:
- shift instructions SLL/SRL and inverse conditional jumps JNC/JNZ;
- a sticky halt state with resume handshake;
- single-instruction step mode and status outputs for the front panel.

Parameters:
OPCODE_W, 4, opcode width; opcodes above 4'b1111 range decode as NOP
ALU_OP_W, 2, alu_op width (min 2)
SEL_W, 4, bus_selector width (min 3)
STEP_W, 3, step counter width (must hold T0..T4)

Ports:
clock  in  1  system clock; all state and outputs update on falling edge
bReset  in  1  asynchronous, active-low reset
instruction  in  OPCODE_W  opcode field of instruction register
carry_flag  in  1  registered carry flag
zero_flag  in  1  registered zero flag
resume  in  1  level, sampled on falling edge; leaves HALTED
step_mode  in  1  1 = pause before each instruction fetch
step_req  in  1  level, sampled on falling edge; releases one instruction in step mode
hlt  out  1  high while HALTED
memory_in, ram_in, instruction_in, reg_a_in, reg_b_in, out_in, advance_pc, pc_in, flags_in  out  1 each  control strobes
alu_op  out  ALU_OP_W  0 ADD, 1 SUB, 2 SLL, 3 SRL
bus_selector  out  SEL_W  0 None, 1 PC, 2 RegA, 3 ALU, 4 RegB, 5 Memory, 6 IR
step  out  STEP_W  step about to be issued (T-index)
paused  out  1  high while held at T0 in step mode
instr_done  out  1  high together with the final step's strobes of an instruction

Behaviour:
- Reset (bReset=0, asynchronous): every output 0, step=0, state RUN. Mid-instruction reset aborts immediately with no partial strobes.
- Issue model: on each falling edge, all strobes clear, then the strobes for the current step are driven, and step advances or returns to 0. Strobes last exactly one clock.
- Fetch, all opcodes:
  - T0: bus=PC, memory_in.
  - T1: bus=Memory, instruction_in, advance_pc.
- Execute steps, T2 onward; the last listed step also asserts instr_done and returns step to 0:
  - NOP 0000 and undefined opcodes: T2 emits nothing.
  - LDA 0001: T2 bus=IR, memory_in. T3 bus=Memory, reg_a_in.
  - ADD 0010 / SUB 0011: T2 bus=IR, memory_in. T3 bus=Memory, reg_b_in. T4 bus=ALU, reg_a_in, flags_in, alu_op=0 or 1. Flags are latched on the writeback step, not T3.
  - STA 0100: T2 bus=IR, memory_in. T3 bus=RegA, ram_in.
  - LDI 0101: T2 bus=IR, reg_a_in.
  - JMP 0110: T2 bus=IR, pc_in.
  - JC 0111, JZ 1000, JNC 1011, JNZ 1100: T2 bus=IR, pc_in when the condition holds (carry / zero / !carry / !zero), otherwise T2 emits nothing. Flags are sampled at the T2 edge.
  - SLL 1001 / SRL 1010: T2 bus=ALU, reg_a_in, flags_in, alu_op=2 or 3.
  - OUT 1110: T2 bus=RegA, out_in.
  - HLT 1111: T2 asserts hlt and instr_done, then enters HALTED.
- HALTED:
  - hlt=1, all other strobes 0, step=0.
  - An edge with resume=1 drives hlt to 0, emits nothing, and enters RUN at T0.
  - resume is ignored outside HALTED.
- Step mode:
  - In RUN at T0 with step_mode=1 and step_req=0, emit nothing, paused=1, hold.
  - An edge with step_req=1 at T0 issues T0 normally, sets paused=0, and runs the whole instruction. step_req is ignored at other steps.
  - Holding step_req high runs continuously.
  - step_mode changes take effect only at T0.
- Simultaneous events:
  - HLT completing with step_mode=1: HALTED takes precedence.
  - resume and step_mode both high in HALTED: exit to T0, then the pause rule applies on the next edge.
- An opcode change during T2..T4 is not guarded; the IR is stable by design.

Test Plan:
- bReset low mid-ADD at T3 → on the same cycle all outputs 0, step=0; after release, next edge issues T0 (bus=1, memory_in=1).
- ADD opcode 0010 → T0 bus=1; T1 bus=5 + instruction_in + advance_pc; T2 bus=6 + memory_in; T3 bus=5 + reg_b_in; T4 bus=3 + reg_a_in + flags_in, alu_op=0, instr_done=1; next edge back to T0.
- JNZ 1100 with zero_flag=0 → T2 bus=6, pc_in=1, instr_done=1. With zero_flag=1 → T2 all strobes 0, instr_done=1.
- SRL 1010 → T2 bus=3, alu_op=3, reg_a_in=1, flags_in=1, instr_done=1. Undefined opcode 1101 → T2 nothing, instr_done=1.
- HLT → hlt=1 held for 10 edges with resume=0. resume=1 for one edge → hlt=0, next edge T0 fetch.
- step_mode=1, LDI program → paused=1 and no strobes for 5 edges. step_req pulse → T0..T2 issued once, then paused=1 again at T0.

Source files
------------

// File: rtl/control_seq.sv
// Microcoded control sequencer: decodes the IR opcode into per-step control strobes and a bus select.
// Latency: strobes for a step are registered on the falling edge that issues it and last one clock.
// Backpressure: none on the datapath; step mode holds at T0 until step_req, HALTED holds until resume.
module control_seq #(
    parameter int OPCODE_W = 4,
    parameter int ALU_OP_W = 2,
    parameter int SEL_W    = 4,
    parameter int STEP_W   = 3
) (
    input  logic                clock,
    input  logic                bReset,
    input  logic [OPCODE_W-1:0] instruction,
    input  logic                carry_flag,
    input  logic                zero_flag,
    input  logic                resume,
    input  logic                step_mode,
    input  logic                step_req,
    output logic                hlt,
    output logic                memory_in,
    output logic                ram_in,
    output logic                instruction_in,
    output logic                reg_a_in,
    output logic                reg_b_in,
    output logic                out_in,
    output logic                advance_pc,
    output logic                pc_in,
    output logic                flags_in,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [SEL_W-1:0]    bus_selector,
    output logic [STEP_W-1:0]   step,
    output logic                paused,
    output logic                instr_done
);

    typedef enum logic {ST_RUN, ST_HALTED} state_t;

    localparam logic [SEL_W-1:0] BUS_NONE = SEL_W'(0);
    localparam logic [SEL_W-1:0] BUS_PC   = SEL_W'(1);
    localparam logic [SEL_W-1:0] BUS_REGA = SEL_W'(2);
    localparam logic [SEL_W-1:0] BUS_ALU  = SEL_W'(3);
    localparam logic [SEL_W-1:0] BUS_MEM  = SEL_W'(5);
    localparam logic [SEL_W-1:0] BUS_IR   = SEL_W'(6);

    localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] ALU_SLL = ALU_OP_W'(2);
    localparam logic [ALU_OP_W-1:0] ALU_SRL = ALU_OP_W'(3);

    localparam logic [STEP_W-1:0] T0 = STEP_W'(0);
    localparam logic [STEP_W-1:0] T1 = STEP_W'(1);
    localparam logic [STEP_W-1:0] T2 = STEP_W'(2);
    localparam logic [STEP_W-1:0] T3 = STEP_W'(3);

    localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(1);
    localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] OP_STA = OPCODE_W'(4);
    localparam logic [OPCODE_W-1:0] OP_LDI = OPCODE_W'(5);
    localparam logic [OPCODE_W-1:0] OP_JMP = OPCODE_W'(6);
    localparam logic [OPCODE_W-1:0] OP_JC  = OPCODE_W'(7);
    localparam logic [OPCODE_W-1:0] OP_JZ  = OPCODE_W'(8);
    localparam logic [OPCODE_W-1:0] OP_SLL = OPCODE_W'(9);
    localparam logic [OPCODE_W-1:0] OP_SRL = OPCODE_W'(10);
    localparam logic [OPCODE_W-1:0] OP_JNC = OPCODE_W'(11);
    localparam logic [OPCODE_W-1:0] OP_JNZ = OPCODE_W'(12);
    localparam logic [OPCODE_W-1:0] OP_OUT = OPCODE_W'(14);
    localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(15);

    state_t              state_q, state_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic                hlt_d, mem_d, ram_d, ir_d, a_d, b_d, out_d, adv_d, pc_d, fl_d;
    logic [ALU_OP_W-1:0] alu_d;
    logic [SEL_W-1:0]    bus_d;
    logic                paused_d, done_d, last, halt_now, jump_taken;

    assign step = step_q;

    always_comb begin
        jump_taken = 1'b0;
        case (instruction)
            OP_JC:   jump_taken = carry_flag;
            OP_JZ:   jump_taken = zero_flag;
            OP_JNC:  jump_taken = !carry_flag;
            OP_JNZ:  jump_taken = !zero_flag;
            default: jump_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        hlt_d    = 1'b0;
        mem_d    = 1'b0;
        ram_d    = 1'b0;
        ir_d     = 1'b0;
        a_d      = 1'b0;
        b_d      = 1'b0;
        out_d    = 1'b0;
        adv_d    = 1'b0;
        pc_d     = 1'b0;
        fl_d     = 1'b0;
        alu_d    = ALU_ADD;
        bus_d    = BUS_NONE;
        paused_d = 1'b0;
        done_d   = 1'b0;
        last     = 1'b0;
        halt_now = 1'b0;

        case (state_q)
            ST_HALTED: begin
                step_d = T0;
                if (resume) state_d = ST_RUN;
                else        hlt_d   = 1'b1;
            end
            default: begin
                if (step_q == T0 && step_mode && !step_req) begin
                    paused_d = 1'b1;
                end else begin
                    case (step_q)
                        T0: begin
                            bus_d = BUS_PC;
                            mem_d = 1'b1;
                        end
                        T1: begin
                            bus_d = BUS_MEM;
                            ir_d  = 1'b1;
                            adv_d = 1'b1;
                        end
                        default: begin
                            // Execute steps; each opcode's final step raises last.
                            case (instruction)
                                OP_LDA, OP_STA: begin
                                    if (step_q == T2) begin
                                        bus_d = BUS_IR;
                                        mem_d = 1'b1;
                                    end else if (instruction == OP_LDA) begin
                                        bus_d = BUS_MEM;
                                        a_d   = 1'b1;
                                        last  = 1'b1;
                                    end else begin
                                        bus_d = BUS_REGA;
                                        ram_d = 1'b1;
                                        last  = 1'b1;
                                    end
                                end
                                OP_ADD, OP_SUB: begin
                                    if (step_q == T2) begin
                                        bus_d = BUS_IR;
                                        mem_d = 1'b1;
                                    end else if (step_q == T3) begin
                                        bus_d = BUS_MEM;
                                        b_d   = 1'b1;
                                    end else begin
                                        bus_d = BUS_ALU;
                                        a_d   = 1'b1;
                                        fl_d  = 1'b1;
                                        alu_d = (instruction == OP_SUB) ? ALU_SUB : ALU_ADD;
                                        last  = 1'b1;
                                    end
                                end
                                OP_LDI: begin
                                    bus_d = BUS_IR;
                                    a_d   = 1'b1;
                                    last  = 1'b1;
                                end
                                OP_JMP: begin
                                    bus_d = BUS_IR;
                                    pc_d  = 1'b1;
                                    last  = 1'b1;
                                end
                                OP_JC, OP_JZ, OP_JNC, OP_JNZ: begin
                                    if (jump_taken) begin
                                        bus_d = BUS_IR;
                                        pc_d  = 1'b1;
                                    end
                                    last = 1'b1;
                                end
                                OP_SLL, OP_SRL: begin
                                    bus_d = BUS_ALU;
                                    a_d   = 1'b1;
                                    fl_d  = 1'b1;
                                    alu_d = (instruction == OP_SRL) ? ALU_SRL : ALU_SLL;
                                    last  = 1'b1;
                                end
                                OP_OUT: begin
                                    bus_d = BUS_REGA;
                                    out_d = 1'b1;
                                    last  = 1'b1;
                                end
                                OP_HLT: begin
                                    hlt_d    = 1'b1;
                                    halt_now = 1'b1;
                                    last     = 1'b1;
                                end
                                default: last = 1'b1;
                            endcase
                        end
                    endcase

                    if (last) begin
                        step_d = T0;
                        done_d = 1'b1;
                    end else begin
                        step_d = step_q + STEP_W'(1);
                    end
                    // Halt wins over step mode: HALTED is entered before any pause check.
                    if (halt_now) state_d = ST_HALTED;
                end
            end
        endcase
    end

    always_ff @(negedge clock or negedge bReset) begin
        if (!bReset) begin
            state_q        <= ST_RUN;
            step_q         <= T0;
            hlt            <= 1'b0;
            memory_in      <= 1'b0;
            ram_in         <= 1'b0;
            instruction_in <= 1'b0;
            reg_a_in       <= 1'b0;
            reg_b_in       <= 1'b0;
            out_in         <= 1'b0;
            advance_pc     <= 1'b0;
            pc_in          <= 1'b0;
            flags_in       <= 1'b0;
            alu_op         <= ALU_ADD;
            bus_selector   <= BUS_NONE;
            paused         <= 1'b0;
            instr_done     <= 1'b0;
        end else begin
            state_q        <= state_d;
            step_q         <= step_d;
            hlt            <= hlt_d;
            memory_in      <= mem_d;
            ram_in         <= ram_d;
            instruction_in <= ir_d;
            reg_a_in       <= a_d;
            reg_b_in       <= b_d;
            out_in         <= out_d;
            advance_pc     <= adv_d;
            pc_in          <= pc_d;
            flags_in       <= fl_d;
            alu_op         <= alu_d;
            bus_selector   <= bus_d;
            paused         <= paused_d;
            instr_done     <= done_d;
        end
    end

endmodule

// File: tb/tb_control_seq.sv
// Scoreboarded bench for control_seq: an instruction-level model queues expected per-edge outputs,
// and a monitor on the rising edge compares what the sequencer presents.
module tb_control_seq;

    logic       clock;
    logic       bReset;
    logic [3:0] instruction;
    logic       carry_flag, zero_flag, resume, step_mode, step_req;
    logic       hlt, memory_in, ram_in, instruction_in, reg_a_in, reg_b_in;
    logic       out_in, advance_pc, pc_in, flags_in;
    logic [1:0] alu_op;
    logic [3:0] bus_selector;
    logic [2:0] step;
    logic       paused, instr_done;

    control_seq #(.OPCODE_W(4), .ALU_OP_W(2), .SEL_W(4), .STEP_W(3)) dut (
        .clock(clock), .bReset(bReset), .instruction(instruction),
        .carry_flag(carry_flag), .zero_flag(zero_flag), .resume(resume),
        .step_mode(step_mode), .step_req(step_req), .hlt(hlt),
        .memory_in(memory_in), .ram_in(ram_in), .instruction_in(instruction_in),
        .reg_a_in(reg_a_in), .reg_b_in(reg_b_in), .out_in(out_in),
        .advance_pc(advance_pc), .pc_in(pc_in), .flags_in(flags_in),
        .alu_op(alu_op), .bus_selector(bus_selector), .step(step),
        .paused(paused), .instr_done(instr_done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Strobe order: hlt, memory_in, ram_in, instruction_in, reg_a_in, reg_b_in, out_in, advance_pc, pc_in, flags_in
    typedef struct packed {
        logic [9:0] s;
        logic [1:0] alu;
        logic [3:0] bus;
    } uop_t;

    typedef struct packed {
        uop_t       u;
        logic [2:0] step;
        logic       paused;
        logic       done;
    } obs_t;

    localparam logic [9:0] S_HLT = 10'b1000000000;
    localparam logic [9:0] S_MEM = 10'b0100000000;
    localparam logic [9:0] S_RAM = 10'b0010000000;
    localparam logic [9:0] S_IR  = 10'b0001000000;
    localparam logic [9:0] S_A   = 10'b0000100000;
    localparam logic [9:0] S_B   = 10'b0000010000;
    localparam logic [9:0] S_OUT = 10'b0000001000;
    localparam logic [9:0] S_ADV = 10'b0000000100;
    localparam logic [9:0] S_PC  = 10'b0000000010;
    localparam logic [9:0] S_FL  = 10'b0000000001;

    int   checks = 0;
    int   errors = 0;
    obs_t expq[$];

    bit   m_halted;
    int   m_t;
    uop_t m_plan[$];

    function automatic uop_t mu(input logic [3:0] bus, input logic [9:0] s, input logic [1:0] alu);
        uop_t u;
        u.s   = s;
        u.alu = alu;
        u.bus = bus;
        return u;
    endfunction

    function automatic obs_t sample();
        return {hlt, memory_in, ram_in, instruction_in, reg_a_in, reg_b_in, out_in,
                advance_pc, pc_in, flags_in, alu_op, bus_selector, step, paused, instr_done};
    endfunction

    // Execute-phase microprogram for one instruction, built from the opcode table.
    task automatic build_plan(input logic [3:0] op, input bit c, input bit z);
        bit cond;
        m_plan.delete();
        case (op)
            4'd1: begin m_plan.push_back(mu(6, S_MEM, 0)); m_plan.push_back(mu(5, S_A, 0)); end
            4'd2, 4'd3: begin
                m_plan.push_back(mu(6, S_MEM, 0));
                m_plan.push_back(mu(5, S_B, 0));
                m_plan.push_back(mu(3, S_A | S_FL, (op == 4'd3) ? 2'd1 : 2'd0));
            end
            4'd4: begin m_plan.push_back(mu(6, S_MEM, 0)); m_plan.push_back(mu(2, S_RAM, 0)); end
            4'd5: m_plan.push_back(mu(6, S_A, 0));
            4'd6: m_plan.push_back(mu(6, S_PC, 0));
            4'd7, 4'd8, 4'd11, 4'd12: begin
                cond = (op == 4'd7) ? c : (op == 4'd8) ? z : (op == 4'd11) ? !c : !z;
                m_plan.push_back(cond ? mu(6, S_PC, 0) : mu(0, 0, 0));
            end
            4'd9:  m_plan.push_back(mu(3, S_A | S_FL, 2'd2));
            4'd10: m_plan.push_back(mu(3, S_A | S_FL, 2'd3));
            4'd14: m_plan.push_back(mu(2, S_OUT, 0));
            4'd15: m_plan.push_back(mu(0, S_HLT, 0));
            default: m_plan.push_back(mu(0, 0, 0));
        endcase
    endtask

    // Predicts the outputs after the coming falling edge from the inputs now being driven.
    task automatic model_edge();
        obs_t e;
        uop_t u;
        e = '0;
        if (m_halted) begin
            if (resume) m_halted = 0;
            else        e.u.s = S_HLT;
        end else if (m_t == 0 && step_mode && !step_req) begin
            e.paused = 1'b1;
        end else begin
            if (m_t == 0)      u = mu(1, S_MEM, 0);
            else if (m_t == 1) u = mu(5, S_IR | S_ADV, 0);
            else begin
                if (m_t == 2) build_plan(instruction, carry_flag, zero_flag);
                u = m_plan.pop_front();
            end
            e.u = u;
            if (m_t >= 2 && m_plan.size() == 0) begin
                e.done = 1'b1;
                m_t = 0;
                if (u.s == S_HLT) m_halted = 1;
            end else begin
                m_t++;
            end
            e.step = 3'(m_t);
        end
        expq.push_back(e);
    endtask

    task automatic edge_(input logic [3:0] op, input bit c, input bit z,
                         input bit r, input bit sm, input bit sr);
        instruction = op;
        carry_flag  = c;
        zero_flag   = z;
        resume      = r;
        step_mode   = sm;
        step_req    = sr;
        model_edge();
        @(posedge clock);
        #2;
    endtask

    task automatic run_op(input logic [3:0] op, input bit c, input bit z, input int n);
        for (int i = 0; i < n; i++) edge_(op, c, z, 0, 0, 0);
    endtask

    // Monitor: compares whatever the DUT presents against the oldest queued expectation.
    obs_t mon_exp, mon_act;
    initial begin
        forever begin
            @(posedge clock);
            if (bReset && expq.size() > 0) begin
                mon_exp = expq.pop_front();
                mon_act = sample();
                checks++;
                if (mon_act !== mon_exp) begin
                    errors++;
                    $display("FAIL seq @%0t: got %b required %b (u/step/paused/done)",
                             $time, mon_act, mon_exp);
                end
            end
        end
    end

    initial begin
        logic [3:0] rop;
        bReset = 1'b0;
        instruction = 0; carry_flag = 0; zero_flag = 0;
        resume = 0; step_mode = 0; step_req = 0;
        m_halted = 0; m_t = 0;
        repeat (3) @(posedge clock);
        #2;
        checks++;
        if (sample() !== '0) begin
            errors++;
            $display("FAIL reset_state: got %b required all zero", sample());
        end
        bReset = 1'b1;

        run_op(4'd2, 0, 0, 5);          // ADD
        run_op(4'd3, 1, 1, 5);          // SUB
        run_op(4'd12, 0, 0, 3);         // JNZ taken
        run_op(4'd12, 0, 1, 3);         // JNZ not taken
        run_op(4'd11, 1, 0, 3);         // JNC not taken
        run_op(4'd7, 1, 0, 3);          // JC taken
        run_op(4'd10, 0, 0, 3);         // SRL
        run_op(4'd9, 0, 0, 3);          // SLL
        run_op(4'd13, 0, 0, 3);         // undefined
        run_op(4'd1, 0, 0, 4);          // LDA
        run_op(4'd4, 0, 0, 4);          // STA
        run_op(4'd14, 0, 0, 3);         // OUT

        run_op(4'd15, 0, 0, 3);         // HLT, then hold
        for (int i = 0; i < 10; i++) edge_(4'd15, 0, 0, 0, 0, 0);
        edge_(4'd5, 0, 0, 1, 0, 0);     // resume
        run_op(4'd5, 0, 0, 3);

        for (int i = 0; i < 5; i++) edge_(4'd5, 0, 0, 0, 1, 0);
        edge_(4'd5, 0, 0, 0, 1, 1);
        for (int i = 0; i < 5; i++) edge_(4'd5, 0, 0, 0, 1, 0);
        edge_(4'd5, 0, 0, 0, 1, 1);
        for (int i = 0; i < 2; i++) edge_(4'd5, 0, 0, 0, 1, 1);   // held high runs on
        for (int i = 0; i < 4; i++) edge_(4'd5, 0, 0, 0, 0, 0);

        run_op(4'd15, 0, 0, 3);         // HLT with resume+step_mode exit
        edge_(4'd5, 0, 0, 1, 1, 0);
        edge_(4'd5, 0, 0, 1, 1, 0);
        edge_(4'd5, 0, 0, 0, 0, 0);
        run_op(4'd5, 0, 0, 2);

        run_op(4'd2, 0, 0, 4);          // ADD up to T3, then async reset
        bReset = 1'b0;
        #1;
        checks++;
        if (sample() !== '0) begin
            errors++;
            $display("FAIL async_reset_midadd: got %b required all zero", sample());
        end
        m_halted = 0; m_t = 0; m_plan.delete();
        @(posedge clock);
        #2;
        bReset = 1'b1;
        run_op(4'd2, 0, 0, 5);

        rop = 4'd0;
        for (int i = 0; i < 2000; i++) begin
            if (m_t < 2) rop = 4'($urandom_range(0, 15));
            edge_(rop, 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) == 0), 1'($urandom));
        end

        @(posedge clock);
        #1;
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", expq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
